mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: NBDATA, default 32, data width; MDATAW, default 8, data-memory address width; NCORES, default 4, number of requesting cores (2..8); LOCK_MAX, default 16, maximum locked-ownership cycles.
REQ-002 Ports SHALL be:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous, active-high reset
 req  in  NCORES  per-core access request, held until granted
 wr  in  NCORES  per-core write (1) / read (0) qualifier
 lock  in  NCORES  per-core lock request (used only with MEM_ARB_LOCK_EN)
 addr  in  NCORES*MDATAW  per-core address, core k in bits [k*MDATAW +: MDATAW]
 wdata  in  NCORES*NBDATA  per-core write data, core k in bits [k*NBDATA +: NBDATA]
 gnt  out  NCORES  registered one-hot grant pulse
 rvalid  out  NCORES  registered one-hot read-data-valid pulse
 rdata  out  NBDATA  shared read data, valid where rvalid set
 m_wr  out  1  memory write enable, registered
 m_addr  out  MDATAW  memory address, registered
 m_wdata  out  NBDATA  memory write data, registered
 m_rdata  in  NBDATA  memory read data, one-cycle synchronous latency
 lock_abort  out  1  one-cycle pulse on forced lock release
REQ-003 Clock and reset SHALL be exactly as fixed: one clock clk; rst synchronous, active-high.

Function
REQ-004 Arbitration SHALL occur every cycle among cores with req=1, excluding any core whose gnt is 1 in that cycle.
REQ-005 Priority SHALL be round-robin: search starts at (last granted index + 1) mod NCORES, wrapping past NCORES-1 to 0.
REQ-006 Winner decided in cycle t SHALL see gnt high in cycle t+1, with m_wr/m_addr/m_wdata carrying its wr/addr/wdata in the same cycle t+1.
REQ-007 When no core is eligible, gnt SHALL be 0 and m_wr SHALL be 0; m_addr/m_wdata SHALL hold their last values.
REQ-008 For a granted read in cycle t+1, rvalid of that core SHALL pulse in t+2 with rdata = m_rdata; granted writes SHALL produce no rvalid.
REQ-009 Throughput SHALL be one access per cycle when two or more cores request; a single requesting core SHALL be granted at most every second cycle (REQ-004 mask).
REQ-010 A core dropping req before grant SHALL lose its request with no side effect.
REQ-011 State machine: ARB (normal round-robin) and LOCKED (single owner); without MEM_ARB_LOCK_EN only ARB exists.
REQ-012 gnt, rvalid and lock_abort SHALL each be one-hot or zero in every cycle.

Reset
REQ-013 While rst=1 at a clock edge: gnt=0, rvalid=0, rdata=0, m_wr=0, m_addr=0, m_wdata=0, lock_abort=0, state=ARB, lock counter=0, last-granted pointer=NCORES-1 (core 0 first priority).
REQ-014 Reset asserted mid-operation SHALL suppress the rvalid of any read granted in the cycle before reset; no stale rvalid after release.

Configuration
REQ-015 Macro MEM_ARB_LOCK_EN defined: a grant to core k with lock[k]=1 SHALL move ARB->LOCKED, owner k; in LOCKED only core k is eligible; owner's granted access with lock[k]=0 SHALL return to ARB after that grant; after LOCK_MAX cycles in LOCKED the block SHALL return to ARB and pulse lock_abort for one cycle.
REQ-016 Macro MEM_ARB_LOCK_EN undefined: lock input SHALL be ignored, lock_abort SHALL be constant 0, no lock counter logic.

Verification
REQ-017 Reset, then req=4'b1111 all reads, held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; rvalid follows each gnt one cycle later.
REQ-018 Only core 2 requests, write addr=8'h10 wdata=32'hDEADBEEF, held 4 cycles -> gnt=0100 on alternate cycles, m_wr=1 m_addr=8'h10 m_wdata=32'hDEADBEEF in grant cycles, rvalid never set.
REQ-019 Core 1 read addr=8'h05 with memory word 32'h12345678 -> gnt=0010 at t+1, rvalid=0010 and rdata=32'h12345678 at t+2.
REQ-020 Read granted to core 3, rst pulsed next cycle -> rvalid stays 0, all outputs at reset values, next grant goes to core 0 if requested.
REQ-021 MEM_ARB_LOCK_EN: core 0 req+lock held, core 1 requesting -> only core 0 granted; lock never dropped -> after 16 cycles lock_abort=1 for one cycle, core 1 granted next.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives NCORES cores access to one synchronous data memory.
// Defining MEM_ARB_LOCK_EN adds locked ownership with a LOCK_MAX-cycle timeout.
module mem_arbiter #(
    parameter int NBDATA   = 32,
    parameter int MDATAW   = 8,
    parameter int NCORES   = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        req,
    input  logic [NCORES-1:0]        wr,
    input  logic [NCORES-1:0]        lock,
    input  logic [NCORES*MDATAW-1:0] addr,
    input  logic [NCORES*NBDATA-1:0] wdata,
    output logic [NCORES-1:0]        gnt,
    output logic [NCORES-1:0]        rvalid,
    output logic [NBDATA-1:0]        rdata,
    output logic                     m_wr,
    output logic [MDATAW-1:0]        m_addr,
    output logic [NBDATA-1:0]        m_wdata,
    input  logic [NBDATA-1:0]        m_rdata,
    output logic                     lock_abort
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [NCORES-1:0] r_gnt;
    logic [NCORES-1:0] r_rvalid;
    logic              r_m_wr;
    logic [MDATAW-1:0] r_m_addr;
    logic [NBDATA-1:0] r_m_wdata;
    logic [IW-1:0]     r_last;

    logic [NCORES-1:0] w_mask;
    logic [NCORES-1:0] w_elig;
    logic [NCORES-1:0] w_win_oh;
    logic [IW-1:0]     w_win;
    logic [IW-1:0]     w_idx;
    logic              w_found;

    // A core holding gnt this cycle sits out so its held req is not re-granted
    assign w_elig = req & ~r_gnt & w_mask;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NCORES; i++) begin
            w_idx = IW'((int'(r_last) + i) % NCORES);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_oh = w_found ? (NCORES'(1) << w_win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_rvalid  <= '0;
            r_m_wr    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_last    <= IW'(NCORES - 1);
        end else begin
            r_gnt    <= w_win_oh;
            r_m_wr   <= w_found & wr[w_win];
            r_rvalid <= r_m_wr ? '0 : r_gnt;
            if (w_found) begin
                r_m_addr  <= addr[int'(w_win)*MDATAW +: MDATAW];
                r_m_wdata <= wdata[int'(w_win)*NBDATA +: NBDATA];
                r_last    <= w_win;
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_owner_nxt;
    logic [CW-1:0] r_lock_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_abort;
    logic          r_lock_abort;

    assign w_mask = (r_state == LOCKED) ? (NCORES'(1) << r_owner) : '1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = '0;
        w_abort     = 1'b0;
        unique case (r_state)
            ARB: begin
                if (w_found && lock[w_win]) begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_win;
                end
            end
            LOCKED: begin
                // Timeout wins over any access granted in the same cycle
                if (r_lock_cnt == CW'(LOCK_MAX - 1)) begin
                    w_state_nxt = ARB;
                    w_abort     = 1'b1;
                end else if (w_found && !lock[w_win]) begin
                    w_state_nxt = ARB;
                end else begin
                    w_cnt_nxt = r_lock_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB;
            r_owner      <= '0;
            r_lock_cnt   <= '0;
            r_lock_abort <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_lock_cnt   <= w_cnt_nxt;
            r_lock_abort <= w_abort;
        end
    end

    assign lock_abort = r_lock_abort;
`else
    logic w_unused;

    assign w_mask     = '1;
    assign lock_abort = 1'b0;
    assign w_unused   = (^lock) ^ (LOCK_MAX > 0);
`endif

    assign gnt     = r_gnt;
    assign rvalid  = r_rvalid;
    assign rdata   = (|r_rvalid) ? m_rdata : '0;
    assign m_wr    = r_m_wr;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle behavioural model plus directed vectors.
// The lock scenario is exercised when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

    localparam int NB = 32;
    localparam int MW = 8;
    localparam int NC = 4;
    localparam int LM = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    req;
    logic [NC-1:0]    wr;
    logic [NC-1:0]    lock;
    logic [NC*MW-1:0] addr;
    logic [NC*NB-1:0] wdata;
    logic [NC-1:0]    gnt;
    logic [NC-1:0]    rvalid;
    logic [NB-1:0]    rdata;
    logic             m_wr;
    logic [MW-1:0]    m_addr;
    logic [NB-1:0]    m_wdata;
    logic [NB-1:0]    m_rdata;
    logic             lock_abort;

    int errs   = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NBDATA  (NB),
        .MDATAW  (MW),
        .NCORES  (NC),
        .LOCK_MAX(LM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .lock_abort(lock_abort)
    );

    function automatic logic [31:0] rom_val(logic [7:0] a);
        if (a == 8'h05) return 32'h12345678;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Read-only memory with one cycle of latency
    always @(posedge clk) m_rdata <= rom_val(m_addr);

    typedef struct packed {
        logic [3:0]  g;
        logic        mw;
        logic [7:0]  ma;
        logic [31:0] md;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        ab;
        logic        locked;
        logic [1:0]  owner;
        logic [7:0]  lcyc;
        logic [1:0]  last;
    } ms_t;

    ms_t ms;

    function automatic ms_t mdl_reset();
        ms_t s;
        s      = '0;
        s.last = 2'(NC - 1);
        return s;
    endfunction

    function automatic ms_t mdl_step(ms_t s);
        ms_t n;
        int  win;
        int  c;
        n    = s;
        win  = -1;
        n.rv = (s.g != 0 && !s.mw) ? s.g : 4'b0;
        n.rd = rom_val(s.ma);
        n.ab = 1'b0;
        for (int k = 1; k <= NC; k++) begin
            c = (int'(s.last) + k) % NC;
            if (win < 0 && req[c] && !s.g[c] &&
                (!s.locked || c == int'(s.owner)))
                win = c;
        end
`ifdef MEM_ARB_LOCK_EN
        if (s.locked) begin
            n.lcyc = s.lcyc + 8'd1;
            if (int'(n.lcyc) == LM) begin
                n.locked = 1'b0;
                n.ab     = 1'b1;
            end else if (win >= 0 && !lock[win]) begin
                n.locked = 1'b0;
            end
        end else if (win >= 0 && lock[win]) begin
            n.locked = 1'b1;
            n.owner  = 2'(win);
            n.lcyc   = 8'd0;
        end
`endif
        n.g  = (win >= 0) ? 4'(1 << win) : 4'b0;
        n.mw = (win >= 0) ? wr[win] : 1'b0;
        if (win >= 0) begin
            n.ma   = addr[win*MW +: MW];
            n.md   = wdata[win*NB +: NB];
            n.last = 2'(win);
        end
        return n;
    endfunction

    always @(posedge clk) ms <= rst ? mdl_reset() : mdl_step(ms);

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed value
    task automatic lit(string nm, logic [31:0] d, logic [31:0] m,
                       logic [31:0] exp);
        chk({nm, "_dut"}, d, exp);
        chk({nm, "_mdl"}, m, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gnt", 32'(gnt), 32'(ms.g));
            chk("rvalid", 32'(rvalid), 32'(ms.rv));
            if (ms.rv != 0) chk("rdata", rdata, ms.rd);
            chk("m_wr", 32'(m_wr), 32'(ms.mw));
            chk("m_addr", 32'(m_addr), 32'(ms.ma));
            chk("m_wdata", m_wdata, ms.md);
            chk("lock_abort", 32'(lock_abort), 32'(ms.ab));
        end
    end

    task automatic set_core(int k, logic [7:0] a, logic [31:0] d);
        addr[k*MW +: MW]  = a;
        wdata[k*NB +: NB] = d;
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] vec_req[6] = '{4'b1010, 4'b0110, 4'b1101, 4'b1111, 4'b0001, 4'b1001};
    logic [3:0] vec_wr [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b0000, 4'b0001};

    initial begin
        rst   = 1'b1;
        req   = '0;
        wr    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        for (int k = 0; k < NC; k++)
            set_core(k, 8'(8'h20 + k), 32'hA000_0000 + k);
        step(2);
        cmp_en = 1'b1;
        lit("rst_gnt", 32'(gnt), 32'(ms.g), 0);
        lit("rst_rvalid", 32'(rvalid), 32'(ms.rv), 0);
        lit("rst_m_wr", 32'(m_wr), 32'(ms.mw), 0);
        lit("rst_m_addr", 32'(m_addr), 32'(ms.ma), 0);
        lit("rst_m_wdata", m_wdata, ms.md, 0);
        chk("rst_rdata", rdata, 0);

        // All four cores read continuously
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step(1);
            lit("rr_gnt", 32'(gnt), 32'(ms.g), 32'(rr_seq[i]));
            if (i > 0)
                lit("rr_rvalid", 32'(rvalid), 32'(ms.rv), 32'(rr_seq[i-1]));
            if (i == 1) lit("rr_rdata", rdata, ms.rd, 32'h20DF7AC3);
        end
        req = '0;
        step(2);

        // Single read from core 1
        set_core(1, 8'h05, 32'h0);
        req = 4'b0010;
        step(1);
        lit("rd_gnt", 32'(gnt), 32'(ms.g), 32'h2);
        lit("rd_m_addr", 32'(m_addr), 32'(ms.ma), 32'h05);
        req = '0;
        step(1);
        lit("rd_rvalid", 32'(rvalid), 32'(ms.rv), 32'h2);
        lit("rd_rdata", rdata, ms.rd, 32'h12345678);
        step(1);

        // Lone writer: granted every other cycle
        set_core(2, 8'h10, 32'hDEADBEEF);
        req = 4'b0100;
        wr  = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step(1);
            lit("wr_gnt", 32'(gnt), 32'(ms.g), (i % 2 == 0) ? 32'h4 : 32'h0);
            lit("wr_m_wr", 32'(m_wr), 32'(ms.mw), (i % 2 == 0) ? 32'h1 : 32'h0);
            lit("wr_m_addr", 32'(m_addr), 32'(ms.ma), 32'h10);
            lit("wr_m_wdata", m_wdata, ms.md, 32'hDEADBEEF);
            lit("wr_rvalid", 32'(rvalid), 32'(ms.rv), 0);
        end
        req = '0;
        wr  = '0;
        step(1);
        lit("wr_rvalid_end", 32'(rvalid), 32'(ms.rv), 0);

        // Core 1 withdraws while core 0 is being served
        req = 4'b0011;
        step(1);
        lit("drop_gnt0", 32'(gnt), 32'(ms.g), 32'h1);
        req = '0;
        step(1);
        lit("drop_gnt1", 32'(gnt), 32'(ms.g), 0);
        step(1);
        lit("drop_gnt2", 32'(gnt), 32'(ms.g), 0);

        // Mixed request/write patterns, checked by the model
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < NC; k++)
                set_core(k, 8'(v*16 + k), 32'(v*256 + k*17 + 1));
            req = vec_req[v];
            wr  = vec_wr[v];
            step(3);
        end
        req = '0;
        wr  = '0;
        step(2);

        // Reset lands while a core 3 read is in flight
        set_core(3, 8'h33, 32'h0);
        req = 4'b1000;
        step(1);
        lit("rs_gnt", 32'(gnt), 32'(ms.g), 32'h8);
        req = '0;
        rst = 1'b1;
        step(1);
        lit("rs_gnt_r", 32'(gnt), 32'(ms.g), 0);
        lit("rs_rvalid_r", 32'(rvalid), 32'(ms.rv), 0);
        lit("rs_m_addr_r", 32'(m_addr), 32'(ms.ma), 0);
        lit("rs_m_wr_r", 32'(m_wr), 32'(ms.mw), 0);
        chk("rs_rdata_r", rdata, 0);
        rst = 1'b0;
        req = 4'b1001;
        step(1);
        lit("rs_gnt_next", 32'(gnt), 32'(ms.g), 32'h1);
        lit("rs_rvalid_next", 32'(rvalid), 32'(ms.rv), 0);
        req = '0;
        step(1);
        lit("rs_rvalid_c0", 32'(rvalid), 32'(ms.rv), 32'h1);
        step(1);

        rst = 1'b1;
        step(1);
        rst  = 1'b0;
        req  = 4'b0011;
`ifdef MEM_ARB_LOCK_EN
        // Core 0 holds its lock until the timeout
        lock = 4'b0001;
        for (int i = 1; i <= 18; i++) begin
            step(1);
            lit("lk_abort", 32'(lock_abort), 32'(ms.ab), (i == 17) ? 32'h1 : 32'h0);
            if (i <= 17)
                lit("lk_gnt", 32'(gnt), 32'(ms.g), (i % 2 == 1) ? 32'h1 : 32'h0);
            else
                lit("lk_gnt_c1", 32'(gnt), 32'(ms.g), 32'h2);
        end
`else
        // Lock requests have no effect
        lock = 4'b1111;
        step(1);
        lit("nolk_gnt0", 32'(gnt), 32'(ms.g), 32'h1);
        step(1);
        lit("nolk_gnt1", 32'(gnt), 32'(ms.g), 32'h2);
        lit("nolk_abort", 32'(lock_abort), 32'(ms.ab), 0);
`endif
        req  = '0;
        lock = '0;
        step(3);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
